systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Operand staging and skew stage directly upstream of the 4x4 systolic multiplier array.
- Accepts matrices A and B word-serially over a valid/ready load port and stores them locally.
- On start, drives the array's four left inputs (A rows) and four top inputs (B columns) with the diagonal skew the array requires.
- Pulses an accumulator clear before feeding and signals completion once the last partial product has reached PE15.

Parameters:
DATA_W, 32, operand width; matches the array's 32-bit inputs. N is fixed at 4, because the port list is explicit.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
ld_data_i  input  DATA_W  load word
ld_valid_i  input  1  load word valid
ld_ready_o  output  1  feeder can accept a load word
start_i  input  1  begin feed; honoured only in READY
arr_clr_o  output  1  one-cycle pulse to clear array accumulators; the integrator inverts it onto the array's active-low reset
left_o_0, left_o_4, left_o_8, left_o_12  output  DATA_W each  row-skewed A operands into PE0/4/8/12
up_o_0, up_o_1, up_o_2, up_o_3  output  DATA_W each  column-skewed B operands into PE0/1/2/3
busy_o  output  1  high in CLR and FEED
done_o  output  1  one-cycle pulse: array results valid

Behaviour:
- Reset values: all data outputs 0; arr_clr_o, busy_o and done_o are 0; ld_ready_o is 1; state is LOAD; load counter is 0. Buffer contents are don't-care.
- Reset asserted mid-load or mid-feed returns to these values on the next edge; a partial load is discarded.
- States: LOAD, READY, CLR, FEED, DONE.
- LOAD:
  - ld_ready_o=1.
  - Each cycle with ld_valid_i&&ld_ready_o writes ld_data_i at index k, then k increments.
  - k 0..15 -> A[k/4][k%4], i.e. A is row-major.
  - k 16..31 -> B[(k-16)/4][(k-16)%4].
  - The handshake on k=31 moves the state to READY.
  - start_i is ignored in LOAD.
- READY:
  - ld_ready_o=0.
  - start_i=1 -> CLR.
- CLR:
  - Lasts one cycle, with arr_clr_o=1.
  - Data outputs stay 0.
  - Next state is FEED with t=0.
- FEED:
  - Lasts 3N-2=10 cycles, t=0..9.
  - Data outputs are registered from the state and t, and are valid in the same cycle t is held.
  - Left outputs: left_o_(4r) = A[r][t-r] when 0<=t-r<=3, else 0.
  - Top outputs: up_o_c = B[t-c][c] when 0<=t-c<=3, else 0.
  - Non-zero data therefore occupies t=0..6; t=7..9 drive zeros to drain the array.
  - start_i and ld_valid_i are ignored.
- DONE:
  - Lasts one cycle, with done_o=1 and outputs 0.
  - Next state is LOAD with k=0.
  - A new load overwrites the old operands; re-running the same operands requires a reload.
- Latency from start_i sampled high in READY:
  - arr_clr_o is high the cycle after start_i.
  - First operands appear 2 cycles after start_i.
  - done_o is high 12 cycles after start_i.
- Data passes through unmodified: no arithmetic and no width change.

Decomposition:
- Shared package systolic_pkg holds:
  - N=4, DATA_W=32, FEED_LEN=3*N-2, LOAD_LEN=2*N*N.
  - The state enum {LOAD, READY, CLR, FEED, DONE}.
- One sub-module, systolic_skew_lane:
  - Inputs: the four stored words of one A row or one B column, the lane index, t, and a feed-active flag.
  - Output: the registered skewed operand.
  - Instantiated 8 times (4 left lanes, 4 up lanes).

Test Plan:
- Reset, then load 32 words with continuous valid. Required: ld_ready_o drops the cycle after the 32nd handshake, and the state is READY.
- A=identity, B=1..16 row-major, then start. Required:
  - t=0: left_o_0=1, up_o_0=1, all other lanes 0.
  - t=1: up_o_0=5, up_o_1=2, left lanes all 0.
  - t=6: up_o_3=16, left_o_12=1.
  - t=7..9: all lanes 0.
- Apply start_i in LOAD after 20 words. Required: it is ignored. Complete the load, pulse start, and check arr_clr_o 1 cycle later, first data 2 cycles later, and done_o 12 cycles later.
- Toggle ld_valid_i irregularly during load, e.g. a 1-0-0-1 pattern. Required: exactly 32 accepted words, and skewed output matches the golden A/B placement.
- Assert rst_i at FEED t=4. Required: all outputs are 0 on the next edge, the state is LOAD and ld_ready_o=1; a subsequent full load+feed is correct.
- Connect to the 4x4 array with A=[[1..4],[5..8],[9..12],[13..16]] and B=A. Required: at done_o, the array's res_o_0=90 and res_o_15=600.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and state encoding for the systolic operand feeder
package systolic_pkg;

  localparam int N        = 4;
  localparam int DATA_W   = 32;
  localparam int FEED_LEN = 3 * N - 2;
  localparam int LOAD_LEN = 2 * N * N;

  typedef enum logic [2:0] {
    LOAD,
    READY,
    CLR,
    FEED,
    DONE
  } state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - load port, control and skewed operand bundle of the feeder
interface systolic_feeder_if #(parameter int DATA_W = 32);

  logic [DATA_W-1:0] ld_data_i;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic              start_i;
  logic              arr_clr_o;
  logic [DATA_W-1:0] left_o_0;
  logic [DATA_W-1:0] left_o_4;
  logic [DATA_W-1:0] left_o_8;
  logic [DATA_W-1:0] left_o_12;
  logic [DATA_W-1:0] up_o_0;
  logic [DATA_W-1:0] up_o_1;
  logic [DATA_W-1:0] up_o_2;
  logic [DATA_W-1:0] up_o_3;
  logic              busy_o;
  logic              done_o;

  modport master (
    output ld_data_i, ld_valid_i, start_i,
    input  ld_ready_o, arr_clr_o, busy_o, done_o,
    input  left_o_0, left_o_4, left_o_8, left_o_12,
    input  up_o_0, up_o_1, up_o_2, up_o_3
  );

  modport slave (
    input  ld_data_i, ld_valid_i, start_i,
    output ld_ready_o, arr_clr_o, busy_o, done_o,
    output left_o_0, left_o_4, left_o_8, left_o_12,
    output up_o_0, up_o_1, up_o_2, up_o_3
  );

endinterface

// File: rtl/systolic_skew_lane.sv
// rtl/systolic_skew_lane.sv - one registered, diagonally delayed operand lane (A row or B column)
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0][W-1:0] words,
  input  logic [1:0]       lane,
  input  logic [3:0]       t,
  input  logic             feed,
  output logic [W-1:0]     q
);

  logic [3:0] idx;
  logic       sel;

  // Lane i starts its four words i cycles into the feed window.
  always_comb begin
    idx = t - {2'b00, lane};
    sel = feed && (t >= {2'b00, lane}) && (idx <= 4'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (sel) begin
      q <= words[idx[1:0]];
    end else begin
      q <= '0;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - stores A/B word-serially, then feeds them skewed into the 4x4 array
module systolic_feeder #(
  parameter int DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  systolic_feeder_if.slave bus
);
  import systolic_pkg::*;

  state_t     state, state_n;
  logic [4:0] k, k_n;
  logic [3:0] t, t_n;
  logic       feed_n;
  logic       ld_ready, arr_clr, busy, done;

  logic [N-1:0][N-1:0][DATA_W-1:0] a_buf;
  logic [N-1:0][N-1:0][DATA_W-1:0] b_buf;
  logic [N-1:0][N-1:0][DATA_W-1:0] b_col;
  logic [2*N-1:0][DATA_W-1:0]      lane_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= LOAD;
      k     <= '0;
      t     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      t     <= t_n;
    end
  end

  always_comb begin
    state_n  = state;
    k_n      = k;
    t_n      = t;
    ld_ready = 1'b0;
    arr_clr  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (bus.ld_valid_i) begin
          k_n = k + 5'd1;
          if (k == 5'(LOAD_LEN - 1)) begin
            state_n = READY;
            k_n     = '0;
          end
        end
      end
      READY: begin
        if (bus.start_i) state_n = CLR;
      end
      CLR: begin
        arr_clr = 1'b1;
        busy    = 1'b1;
        t_n     = '0;
        state_n = FEED;
      end
      FEED: begin
        busy = 1'b1;
        if (t == 4'(FEED_LEN - 1)) begin
          t_n     = '0;
          state_n = DONE;
        end else begin
          t_n = t + 4'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        k_n     = '0;
        state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  // Lanes register from the next state/t so their outputs line up with the held t.
  assign feed_n = (state_n == FEED);

  always_ff @(posedge clk_i) begin
    if (state == LOAD && bus.ld_valid_i) begin
      if (!k[4]) a_buf[k[3:2]][k[1:0]] <= bus.ld_data_i;
      else       b_buf[k[3:2]][k[1:0]] <= bus.ld_data_i;
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < N; r++) begin
        b_col[c][r] = b_buf[r][c];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_skew_lane #(.W(DATA_W)) u_left (
      .clk   (clk_i),
      .rst   (rst_i),
      .words (a_buf[i]),
      .lane  (2'(i)),
      .t     (t_n),
      .feed  (feed_n),
      .q     (lane_q[i])
    );
    systolic_skew_lane #(.W(DATA_W)) u_up (
      .clk   (clk_i),
      .rst   (rst_i),
      .words (b_col[i]),
      .lane  (2'(i)),
      .t     (t_n),
      .feed  (feed_n),
      .q     (lane_q[N+i])
    );
  end

  assign bus.ld_ready_o = ld_ready;
  assign bus.arr_clr_o  = arr_clr;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;
  assign bus.left_o_0   = lane_q[0];
  assign bus.left_o_4   = lane_q[1];
  assign bus.left_o_8   = lane_q[2];
  assign bus.left_o_12  = lane_q[3];
  assign bus.up_o_0     = lane_q[4];
  assign bus.up_o_1     = lane_q[5];
  assign bus.up_o_2     = lane_q[6];
  assign bus.up_o_3     = lane_q[7];

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder with an output-stationary array model
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_W(32)) bus();
  systolic_feeder #(.DATA_W(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    int                 cyc;
    bit                 clr;
    bit                 done;
    bit                 busy;
    logic [7:0][31:0]   lanes;
    bit                 chk_res;
    logic [15:0][63:0]  res;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [31:0] words[32];

  logic [7:0][31:0] lanes_now;
  assign lanes_now = {bus.up_o_3, bus.up_o_2, bus.up_o_1, bus.up_o_0,
                      bus.left_o_12, bus.left_o_8, bus.left_o_4, bus.left_o_0};

  logic [63:0] acc[4][4];
  logic [31:0] ar[4][4];
  logic [31:0] br[4][4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare against queued expectations, then advance the array model.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a_in, b_in;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("stale_expectation", 64'(cyc), 64'(exp_q[0].cyc));
        e = exp_q.pop_front();
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 8; i++)
          chk($sformatf("lane%0d", i), 64'(lanes_now[i]), 64'(e.lanes[i]));
        chk("arr_clr", 64'(bus.arr_clr_o), 64'(e.clr));
        chk("done", 64'(bus.done_o), 64'(e.done));
        chk("busy", 64'(bus.busy_o), 64'(e.busy));
        chk("ld_ready_busy", 64'(bus.ld_ready_o), 64'd0);
        if (e.chk_res)
          for (int i = 0; i < 16; i++)
            chk($sformatf("res_%0d", i), acc[i/4][i%4], e.res[i]);
      end else begin
        chk("arr_clr_idle", 64'(bus.arr_clr_o), 64'd0);
        chk("done_idle", 64'(bus.done_o), 64'd0);
      end
    end
    if (bus.arr_clr_o === 1'b1) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          acc[r][c] = '0; ar[r][c] = '0; br[r][c] = '0;
        end
    end else begin
      for (int r = 3; r >= 0; r--)
        for (int c = 3; c >= 0; c--) begin
          a_in = (c == 0) ? lanes_now[r] : ar[r][c-1];
          b_in = (r == 0) ? lanes_now[4+c] : br[r-1][c];
          acc[r][c] = acc[r][c] + 64'(a_in) * 64'(b_in);
          ar[r][c] = a_in;
          br[r][c] = b_in;
        end
    end
  end

  task automatic load(input int mode, input int start_at);
    int acc_n = 0;
    int guard = 0;
    int ph = 0;
    bit v;
    bit pulsed = 1'b0;
    while (acc_n < 32 && guard < 1000) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (ph % 4 == 0) || (ph % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph++;
      guard++;
      bus.start_i = 1'b0;
      if (!pulsed && start_at >= 0 && acc_n == start_at) begin
        bus.start_i = 1'b1;
        pulsed = 1'b1;
      end
      bus.ld_valid_i = v;
      bus.ld_data_i  = v ? words[acc_n] : $urandom;
      if (v && bus.ld_ready_o) acc_n++;
    end
    if (acc_n < 32) chk("load_timeout", 64'(acc_n), 64'd32);
    // Extra words after the 32nd must be refused and must not disturb the buffers.
    repeat (3) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      chk("ld_ready_after_load", 64'(bus.ld_ready_o), 64'd0);
      chk("busy_ready", 64'(bus.busy_o), 64'd0);
      bus.ld_valid_i = 1'b1;
      bus.ld_data_i  = $urandom;
    end
    @(negedge clk);
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic run_feed(input bit do_rst);
    exp_t e;
    logic [7:0][31:0] tab[10];
    logic [63:0] sum;
    int s;
    int guard;
    for (int i = 0; i < 10; i++) tab[i] = '0;
    // A[r][k] enters left lane r at t=r+k; B[k][c] enters top lane c at t=k+c.
    for (int r = 0; r < 4; r++)
      for (int kk = 0; kk < 4; kk++) tab[r+kk][r] = words[r*4+kk];
    for (int kk = 0; kk < 4; kk++)
      for (int c = 0; c < 4; c++) tab[kk+c][4+c] = words[16+kk*4+c];
    @(negedge clk);
    s = cyc;
    bus.start_i = 1'b1;
    e.cyc = s + 1; e.clr = 1'b1; e.done = 1'b0; e.busy = 1'b1;
    e.lanes = '0; e.chk_res = 1'b0; e.res = '0;
    exp_q.push_back(e);
    for (int tt = 0; tt < 10; tt++) begin
      e.cyc = s + 2 + tt; e.clr = 1'b0; e.lanes = tab[tt];
      exp_q.push_back(e);
    end
    e.cyc = s + 12; e.busy = 1'b0; e.done = 1'b1; e.lanes = '0; e.chk_res = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sum = '0;
        for (int kk = 0; kk < 4; kk++)
          sum = sum + 64'(words[r*4+kk]) * 64'(words[16+kk*4+c]);
        e.res[r*4+c] = sum;
      end
    exp_q.push_back(e);
    @(negedge clk);
    bus.start_i = 1'b0;
    if (do_rst) begin
      while (cyc < s + 6) @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[$].cyc > s + 6) e = exp_q.pop_back();
      @(negedge clk);
      for (int i = 0; i < 8; i++)
        chk($sformatf("rst_lane%0d", i), 64'(lanes_now[i]), 64'd0);
      chk("rst_arr_clr", 64'(bus.arr_clr_o), 64'd0);
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_done", 64'(bus.done_o), 64'd0);
      chk("rst_ld_ready", 64'(bus.ld_ready_o), 64'd1);
      rst = 1'b0;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) chk("feed_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 32; i++) words[i] = $urandom;
  endtask

  initial begin
    bus.ld_valid_i = 1'b0;
    bus.ld_data_i  = '0;
    bus.start_i    = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++)
      chk($sformatf("reset_lane%0d", i), 64'(lanes_now[i]), 64'd0);
    chk("reset_ld_ready", 64'(bus.ld_ready_o), 64'd1);
    chk("reset_busy", 64'(bus.busy_o), 64'd0);
    chk("reset_arr_clr", 64'(bus.arr_clr_o), 64'd0);
    chk("reset_done", 64'(bus.done_o), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      words[i]    = (i / 4 == i % 4) ? 32'd1 : 32'd0;
      words[16+i] = 32'(i + 1);
    end
    load(0, -1);
    run_feed(1'b0);

    for (int i = 0; i < 16; i++) begin
      words[i]    = 32'(i + 1);
      words[16+i] = 32'(i + 1);
    end
    load(0, -1);
    run_feed(1'b0);

    rand_words();
    load(0, 20);
    run_feed(1'b0);

    rand_words();
    load(1, -1);
    run_feed(1'b0);

    rand_words();
    load(2, -1);
    run_feed(1'b1);
    rand_words();
    load(2, 5);
    run_feed(1'b0);

    repeat (3) begin
      rand_words();
      load(2, -1);
      run_feed(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
